mem_responder: RTL and testbench

Memory-side responder for the SLC-3 core's memory port. It serves the core's mem_* requests from an on-chip word RAM with a fixed, parameterized read latency, and memory-maps one I/O word: switches on read, hex-display register on write. After every reset it zero-fills the RAM before accepting requests.

---
 rtl/mem_resp_pkg.sv | 15 +
 rtl/rd_delay_line.sv | 54 +++++
 rtl/mem_responder.sv | 121 ++++++++++++
 tb/tb_mem_responder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the SLC-3 memory-side responder.
package mem_resp_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  localparam word_t       IO_ADDR_DEFAULT = 16'hFFFF;
  localparam int unsigned READ_LAT_MIN    = 1;
  localparam int unsigned READ_LAT_MAX    = 3;

endpackage

// File: rtl/rd_delay_line.sv
// Valid/data delay line for read results; the last stage holds its data
// until the next valid result arrives, so it doubles as the output register.
module rd_delay_line
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        flush,
  input  logic        in_vld,
  input  logic [15:0] in_data,
  output logic [15:0] out_data
);

  // Valid presented to each stage; stage 0 sees the incoming request.
  logic [DEPTH-1:0] vin;
  word_t            data_q [DEPTH];

  assign vin[0] = in_vld;

  if (DEPTH > 1) begin : g_vld
    logic [DEPTH-2:0] vld_q;

    always_ff @(posedge clk) begin
      if (flush) begin
        vld_q <= '0;
      end else begin
        vld_q <= vin[DEPTH-2:0];
      end
    end

    assign vin[DEPTH-1:1] = vld_q;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      if (vin[0]) begin
        data_q[0] <= in_data;
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (vin[i]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign out_data = data_q[DEPTH-1];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: word RAM with fixed read latency, one memory-mapped
// I/O word (switches / hex register), and zero-fill of the RAM after reset.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned READ_LAT  = 2,
  parameter logic [15:0] IO_ADDR   = IO_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_mem_ena,
  input  logic        mem_wr_ena,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  input  logic [15:0] sw_i,
  output logic [15:0] hex_o,
  output logic        init_busy
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  // Out-of-range latencies are clamped to the supported window.
  localparam int unsigned LAT = (READ_LAT < READ_LAT_MIN) ? READ_LAT_MIN :
                                (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] cnt_q, cnt_d;
  word_t                ram [DEPTH];

  logic                 accept;
  logic                 is_io;
  logic                 in_range;
  logic                 rd_accept;
  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_idx;
  logic [ADDR_BITS-1:0] ram_waddr;
  word_t                ram_wdata;
  word_t                rd_sample;

  assign ram_idx  = mem_addr[ADDR_BITS-1:0];
  assign is_io    = (mem_addr == IO_ADDR);
  assign in_range = ((32'(mem_addr) >> ADDR_BITS) == 32'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    init_busy = 1'b0;
    accept    = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = ram_idx;
    ram_wdata = mem_wdata;
    case (state_q)
      ST_INIT: begin
        init_busy = 1'b1;
        ram_we    = 1'b1;
        ram_waddr = cnt_q;
        ram_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Reset has priority over a request presented in the same cycle.
        accept = mem_mem_ena & ~reset;
        ram_we = accept & mem_wr_ena & in_range & ~is_io;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_waddr] <= ram_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hex_o <= '0;
    end else if (accept && mem_wr_ena && is_io) begin
      hex_o <= mem_wdata;
    end
  end

  // Combinational RAM read: a write at one edge is visible to a read at the next.
  always_comb begin
    rd_sample = '0;
    if (is_io) begin
      rd_sample = sw_i;
    end else if (in_range) begin
      rd_sample = ram[ram_idx];
    end
  end

  assign rd_accept = accept & ~mem_wr_ena;

  rd_delay_line #(
    .DEPTH(LAT)
  ) u_rd_delay_line (
    .clk     (clk),
    .flush   (reset),
    .in_vld  (rd_accept),
    .in_data (rd_sample),
    .out_data(mem_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus random traffic
// compared every cycle against a queue-based behavioural model.
module tb_mem_responder;

  localparam int unsigned ADDR_BITS = 8;
  localparam int unsigned DEPTH     = 256;
  localparam int unsigned READ_LAT  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_mem_ena;
  logic        mem_wr_ena;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] sw_i;
  logic [15:0] hex_o;
  logic        init_busy;

  mem_responder #(
    .ADDR_BITS(ADDR_BITS),
    .READ_LAT (READ_LAT),
    .IO_ADDR  (16'hFFFF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_mem_ena(mem_mem_ena),
    .mem_wr_ena (mem_wr_ena),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .sw_i       (sw_i),
    .hex_o      (hex_o),
    .init_busy  (init_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [15:0] data;
  } pend_t;

  logic [15:0] m_mem [DEPTH];
  logic [15:0] m_hex;
  logic [15:0] exp_rdata;
  logic        exp_busy;
  int unsigned init_left;
  int unsigned edge_no;
  pend_t       pend [$];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check16(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, got, want, edge_no);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b (edge %0d)", tag, got, want, edge_no);
    end
  endtask

  // Apply one cycle of inputs, advance the model by one edge, compare outputs.
  task automatic step(input logic rst, input logic ena, input logic wr,
                      input logic [15:0] addr, input logic [15:0] wdata);
    pend_t       p;
    logic [15:0] d;
    reset       = rst;
    mem_mem_ena = ena;
    mem_wr_ena  = wr;
    mem_addr    = addr;
    mem_wdata   = wdata;
    @(posedge clk);
    edge_no++;
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 16'h0000;
      m_hex     = 16'h0000;
      exp_rdata = 16'h0000;
      pend.delete();
      init_left = DEPTH;
    end else if (init_left > 0) begin
      init_left--;
    end else if (ena) begin
      if (wr) begin
        if (addr == 16'hFFFF) m_hex = wdata;
        else if (addr < DEPTH) m_mem[addr[7:0]] = wdata;
      end else begin
        if (addr == 16'hFFFF) d = sw_i;
        else if (addr < DEPTH) d = m_mem[addr[7:0]];
        else d = 16'h0000;
        p.due  = edge_no + READ_LAT - 1;
        p.data = d;
        pend.push_back(p);
      end
    end
    while (pend.size() > 0 && pend[0].due == edge_no) begin
      p = pend.pop_front();
      exp_rdata = p.data;
    end
    exp_busy = rst || (init_left > 0);
    #1;
    check16("rdata", mem_rdata, exp_rdata);
    check16("hex", hex_o, m_hex);
    check1("busy", init_busy, exp_busy);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic wr_req(input logic [15:0] a, input logic [15:0] d);
    step(1'b0, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd_req(input logic [15:0] a);
    step(1'b0, 1'b1, 1'b0, a, 16'h0000);
  endtask

  task automatic count_init(input int unsigned write_at);
    int unsigned busy_cycles;
    busy_cycles = 0;
    while (init_busy === 1'b1 && busy_cycles < 1000) begin
      busy_cycles++;
      if (busy_cycles == write_at) wr_req(16'h0020, 16'h5555);
      else idle();
    end
    n_vec++;
    assert (busy_cycles == DEPTH) else begin
      n_err++;
      $error("FAIL init_len: observed %0d expected %0d", busy_cycles, DEPTH);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] a;
    int unsigned r;
    edge_no     = 0;
    init_left   = 0;
    sw_i        = 16'h0000;
    reset       = 1'b1;
    mem_mem_ena = 1'b0;
    mem_wr_ena  = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    // Reset, then zero-fill duration.
    repeat (3) step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    count_init(0);

    // First read after init.
    rd_req(16'h0005);
    idle();
    check16("rd_0005", mem_rdata, 16'h0000);

    // Write then read next cycle; result after READ_LAT cycles, then held.
    wr_req(16'h0010, 16'h1234);
    rd_req(16'h0010);
    check16("rd_lat_early", mem_rdata, 16'h0000);
    idle();
    check16("rd_after_wr", mem_rdata, 16'h1234);
    repeat (5) idle();
    check16("rd_hold", mem_rdata, 16'h1234);

    // Back-to-back pipelined reads.
    wr_req(16'h0010, 16'hA001);
    wr_req(16'h0011, 16'hA002);
    wr_req(16'h0012, 16'hA003);
    rd_req(16'h0010);
    rd_req(16'h0011);
    check16("pipe0", mem_rdata, 16'hA001);
    rd_req(16'h0012);
    check16("pipe1", mem_rdata, 16'hA002);
    idle();
    check16("pipe2", mem_rdata, 16'hA003);
    idle();

    // I/O word: switches on read, hex register on write, no RAM alias.
    sw_i = 16'hBEEF;
    rd_req(16'hFFFF);
    sw_i = 16'h0000;
    idle();
    check16("sw_read", mem_rdata, 16'hBEEF);
    wr_req(16'hFFFF, 16'h00C3);
    check16("hex_write", hex_o, 16'h00C3);
    rd_req(16'h00FF);
    idle();
    check16("ram_ff", mem_rdata, 16'h0000);

    // Out-of-range write is discarded and does not alias.
    wr_req(16'h0100, 16'hAAAA);
    rd_req(16'h0100);
    rd_req(16'h0000);
    check16("oor_read", mem_rdata, 16'h0000);
    idle();
    check16("no_alias", mem_rdata, 16'h0000);
    idle();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      sw_i = 16'($urandom);
      r = $urandom_range(0, 9);
      if (r <= 5)      a = 16'($urandom_range(0, 255));
      else if (r == 6) a = 16'hFFFF;
      else if (r == 7) a = 16'($urandom_range(256, 16'hFFFE));
      else             a = 16'($urandom_range(16'h0010, 16'h0013));
      step(1'b0, ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
           a, 16'($urandom));
    end
    idle();
    idle();

    // Reset while a read is in flight: the read must never surface.
    wr_req(16'h0030, 16'h7E57);
    wr_req(16'hFFFF, 16'h0F0F);
    rd_req(16'h0030);
    idle();
    check16("pre_flush", mem_rdata, 16'h7E57);
    wr_req(16'h0030, 16'h1111);
    rd_req(16'h0030);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check16("flush_rdata", mem_rdata, 16'h0000);
    check16("flush_hex", hex_o, 16'h0000);
    check1("flush_busy", init_busy, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    count_init(2);

    // Write issued during INIT was dropped.
    rd_req(16'h0020);
    idle();
    check16("init_wr_dropped", mem_rdata, 16'h0000);
    rd_req(16'h0030);
    idle();
    check16("ram_zeroed", mem_rdata, 16'h0000);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
